debug_seq: RTL
==============

# debug_seq

Command sequencer on the host side of `cpu_core`'s debug port. It accepts stop, run, step, register-read and register-write commands over a valid/ready channel. It drives `debug_mode`, `debug_sel`, `debug_we` and `debug_wdata` with exact cycle discipline, and returns one response per command. It sits between the chip-level debug/IO front end and one core; one instance per core.

## Interface
- `DATA_WIDTH`, 16, width of core registers and debug data.
- `SEL_WIDTH`, 4, width of `debug_sel` (register select).
- `TIMEOUT`, 255, maximum cycles to wait for `debug_stopped`. Must be ≥1 and fit in 8 bits.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted on an edge where valid && ready.
- `cmd_op`  in  3  0 NOP, 1 STOP, 2 RUN, 3 STEP, 4 READ, 5 WRITE; 6–7 are illegal.
- `cmd_sel`  in  SEL_WIDTH  register select for READ/WRITE.
- `cmd_data`  in  DATA_WIDTH  write data (WRITE) or step count (STEP).
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed on an edge where valid && ready.
- `rsp_data`  out  DATA_WIDTH  read data; 0 for all other ops.
- `rsp_err`  out  1  command failed.
- `debug_mode`  out  2  to core: 0 run, 1 stop, 2 step; 3 is never driven.
- `debug_sel`  out  SEL_WIDTH  to core.
- `debug_we`  out  1  to core.
- `debug_wdata`  out  DATA_WIDTH  to core.
- `debug_stopped`  in  1  from core: core is halted.
- `debug_rdata`  in  DATA_WIDTH  from core: combinational read of `debug_sel`.

## Operation
- States: IDLE, STOP_WAIT, STEP_PULSE, STEP_WAIT, READ_SEL, READ_CAP, WRITE, RESP.
- `cmd_ready` = 1 only in IDLE. Every accepted command produces exactly one response; the block goes through RESP and holds it until `rsp_ready`, then returns to IDLE.
- **NOP**: go to RESP; `rsp_err`=0.
- **Illegal op**: go to RESP; `rsp_err`=1.
- **RUN**: set `debug_mode`=0, then RESP.
- **STOP**: set `debug_mode`=1 and go to STOP_WAIT.
  - Clear the timeout counter on entry; increment it each cycle `debug_stopped`=0.
  - `debug_stopped` sampled 1: go to RESP with err=0.
  - Counter reaches `TIMEOUT`: go to RESP with err=1. `debug_mode` stays 1.
- **STEP**: precondition `debug_stopped`=1 at accept, else RESP with err=1 and no mode change.
  - Load the step counter from `cmd_data`. Count 0 goes straight to RESP with err=0.
  - STEP_PULSE: `debug_mode`=2 for exactly one cycle.
  - STEP_WAIT: `debug_mode`=1; wait for `debug_stopped` using the same timeout. Timeout gives err=1.
  - When stopped, decrement the counter. Nonzero → STEP_PULSE; zero → RESP.
- **READ**: precondition stopped, else err=1.
  - READ_SEL drives `debug_sel`=`cmd_sel` (latched).
  - READ_CAP registers `debug_rdata` into `rsp_data`, then RESP.
- **WRITE**: precondition stopped, else err=1.
  - WRITE drives `debug_we`=1, `debug_sel`, and `debug_wdata` for exactly one cycle, then RESP.
- `debug_sel` and `debug_wdata` hold their last values outside READ/WRITE. `debug_we` is 0 outside WRITE.
- `rsp_data`/`rsp_err` are stable while `rsp_valid`=1.
- Arithmetic widths: step counter is DATA_WIDTH bits; timeout counter is 8 bits and saturates.

## Timing
- Reset values:
  - `cmd_ready`=0 during reset, 1 the cycle after.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0.
  - `debug_mode`=0, `debug_sel`=0, `debug_we`=0, `debug_wdata`=0.
  - State IDLE; both counters cleared.
- Reset mid-command: abort immediately. Any pending response is dropped and outputs return to reset values, including `debug_mode`=0, which releases the core.
- All outputs are registered. Accept edge = E0.
  - NOP, RUN, and failed preconditions: `rsp_valid`=1 after E1.
  - WRITE: `debug_we`=1 in the cycle after E0; `rsp_valid` after E1.
  - READ: sel valid after E0, capture at E2, `rsp_valid` after E2.
  - STOP with core already stopped: `rsp_valid` after E2.
- Response handshake: with `rsp_ready` held at 1, the next `cmd_ready` is asserted the cycle after the response edge. Back-to-back throughput for a single-cycle command is therefore one command per 3 cycles.
- The precondition check samples `debug_stopped` on the accept edge only.

## Structure
- Shared package `debug_pkg` holds:
  - opcode localparams `DBG_NOP` … `DBG_WRITE`;
  - mode encodings `MODE_RUN`=0, `MODE_STOP`=1, `MODE_STEP`=2;
  - the state enum.
- `cpu_core` imports the same mode constants.
- One sub-module, `debug_timeout`: loadable 8-bit saturating counter with a `expired` flag, shared by STOP_WAIT and STEP_WAIT.
- The rest is a single FSM.

## Test plan
- **Stop:** reset, STOP, core model raises `debug_stopped` 3 cycles later → `debug_mode`=1, response err=0 `rsp_data`=0, total 5 cycles from accept.
- **Stop timeout:** STOP with `debug_stopped` tied 0 and `TIMEOUT`=255 → response err=1 after 255 wait cycles; `debug_mode` remains 1.
- **Write then read:** stopped core, WRITE sel=1 data=16'h00F3 → exactly one cycle `debug_we`=1 with sel=1; then READ sel=1 → `rsp_data`=16'h00F3, err=0.
- **Step:** STEP count=3 on a stopped core that advances `progctr` once per mode-2 cycle → exactly three mode-2 pulses, `progctr` advances by 3, err=0. STEP count=0 → no pulse.
- **Precondition fail:** READ while the core is running (`debug_stopped`=0) → err=1, `rsp_data`=0, no change on `debug_sel`. Op 7 → err=1.
- **Reset mid-step:** assert `rst` during STEP_WAIT → next cycle `debug_mode`=0 and `rsp_valid`=0; with `rsp_ready`=0, no stale response appears afterwards.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared encodings for the debug sequencer and the core's debug port.
// No logic: opcodes, debug_mode values, and sequencer states.
// Imported by debug_seq, debug_timeout and cpu_core.
package debug_pkg;

  localparam logic [2:0] DBG_NOP   = 3'd0;
  localparam logic [2:0] DBG_STOP  = 3'd1;
  localparam logic [2:0] DBG_RUN   = 3'd2;
  localparam logic [2:0] DBG_STEP  = 3'd3;
  localparam logic [2:0] DBG_READ  = 3'd4;
  localparam logic [2:0] DBG_WRITE = 3'd5;

  localparam logic [1:0] MODE_RUN  = 2'd0;
  localparam logic [1:0] MODE_STOP = 2'd1;
  localparam logic [1:0] MODE_STEP = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STOP_WAIT,
    ST_STEP_PULSE,
    ST_STEP_WAIT,
    ST_READ_SEL,
    ST_READ_CAP,
    ST_WRITE,
    ST_RESP
  } state_e;

  // States in which the sequencer waits for the core to report halted.
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_STOP_WAIT) || (s == ST_STEP_WAIT);
  endfunction

endpackage

// File: rtl/debug_timeout.sv
// Saturating 8-bit wait counter with an expired flag; clears while clr_i is high.
// Latency: expired_o is a compare of the registered count, valid the cycle after the LIMIT-th increment.
// Backpressure: none; it only observes inc_i.
module debug_timeout #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);
  import debug_pkg::*;

  localparam logic [7:0] LIMIT_C = 8'(LIMIT);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear has priority, increment stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q >= LIMIT_C);

endmodule

// File: rtl/debug_seq.sv
// Host-side debug command sequencer: one response per command, drives the core debug port.
// Latency: NOP/RUN/error rsp after E1, WRITE after E1, READ after E2, STOP on halted core after E2.
// Backpressure: cmd_ready only in IDLE; response held stable until rsp_ready.
module debug_seq #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SEL_WIDTH  = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [SEL_WIDTH-1:0]  cmd_sel,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic [1:0]            debug_mode,
  output logic [SEL_WIDTH-1:0]  debug_sel,
  output logic                  debug_we,
  output logic [DATA_WIDTH-1:0] debug_wdata,
  input  logic                  debug_stopped,
  input  logic [DATA_WIDTH-1:0] debug_rdata
);
  import debug_pkg::*;

  state_e                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [1:0]            mode_q, mode_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] step_q, step_d;
  logic                  seen_q, seen_d;
  logic                  expired;

  // Timeout is held clear outside the wait states, so every entry starts at zero.
  debug_timeout #(.LIMIT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (!is_wait_state(state_q)),
    .inc_i     (is_wait_state(state_q) && !debug_stopped),
    .expired_o (expired)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    sel_d      = sel_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    step_d     = step_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
          case (cmd_op)
            DBG_NOP: ;
            DBG_RUN: mode_d = MODE_RUN;
            DBG_STOP: begin
              mode_d  = MODE_STOP;
              state_d = ST_STOP_WAIT;
            end
            DBG_STEP: begin
              if (!debug_stopped) begin
                rsp_err_d = 1'b1;
              end else if (cmd_data != '0) begin
                step_d  = cmd_data;
                mode_d  = MODE_STEP;
                state_d = ST_STEP_PULSE;
              end
            end
            DBG_READ: begin
              if (!debug_stopped) begin
                rsp_err_d = 1'b1;
              end else begin
                sel_d   = cmd_sel;
                state_d = ST_READ_SEL;
              end
            end
            DBG_WRITE: begin
              if (!debug_stopped) begin
                rsp_err_d = 1'b1;
              end else begin
                sel_d   = cmd_sel;
                wdata_d = cmd_data;
                we_d    = 1'b1;
                state_d = ST_WRITE;
              end
            end
            default: rsp_err_d = 1'b1;
          endcase
        end
      end
      ST_STOP_WAIT: begin
        if (seen_q) begin
          state_d = ST_RESP;
        end else if (expired) begin
          rsp_err_d = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_STEP_PULSE: begin
        mode_d  = MODE_STOP;
        state_d = ST_STEP_WAIT;
      end
      ST_STEP_WAIT: begin
        if (seen_q) begin
          step_d = step_q - DATA_WIDTH'(1);
          if (step_q == DATA_WIDTH'(1)) begin
            state_d = ST_RESP;
          end else begin
            mode_d  = MODE_STEP;
            state_d = ST_STEP_PULSE;
          end
        end else if (expired) begin
          rsp_err_d = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_READ_SEL: state_d = ST_READ_CAP;
      ST_READ_CAP: begin
        rsp_data_d = debug_rdata;
        state_d    = ST_RESP;
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Commands answered straight from IDLE spend one RESP cycle before rsp_valid rises.
    if (state_q == ST_RESP) begin
      rsp_valid_d = !(rsp_valid_q && rsp_ready);
    end else begin
      rsp_valid_d = (state_d == ST_RESP) && (state_q != ST_IDLE);
    end
    cmd_ready_d = (state_d == ST_IDLE);
    // Halt is taken from a registered sample, dropped when the wait state is left.
    seen_d = debug_stopped && is_wait_state(state_q) && (state_d == state_q);
  end

  // State and output registers; reset aborts any command and releases the core.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      mode_q      <= MODE_RUN;
      sel_q       <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      step_q      <= '0;
      seen_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      mode_q      <= mode_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      step_q      <= step_d;
      seen_q      <= seen_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign debug_mode  = mode_q;
  assign debug_sel   = sel_q;
  assign debug_we    = we_q;
  assign debug_wdata = wdata_q;

endmodule
